// File: rtl/cpu_datapath.sv
// Register-transfer datapath for the 16-bit RISC core.
// Executes the controller's load/select/write strobes against an 8-entry
// register file, A/B operand registers, a one-bit shifter on B, the ALU,
// result register C and a Z/N/V status register.
module cpu_datapath #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int PC_W   = 8,
  localparam int IDX_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  readnum,
  input  logic [IDX_W-1:0]  writenum,
  input  logic              write,
  input  logic [1:0]        vsel,
  input  logic              loada,
  input  logic              loadb,
  input  logic              asel,
  input  logic              bsel,
  input  logic [1:0]        shift,
  input  logic [1:0]        alu_op,
  input  logic              loadc,
  input  logic              loads,
  input  logic [DATA_W-1:0] sximm8,
  input  logic [DATA_W-1:0] sximm5,
  input  logic [DATA_W-1:0] mdata,
  input  logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] datapath_out,
  output logic              z_flag,
  output logic              n_flag,
  output logic              v_flag
);

  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [DATA_W-1:0] rdata, wb_data;
  logic [DATA_W-1:0] a_q, b_q, c_q;
  logic [DATA_W-1:0] b_sh, ain, bin, result;
  flags_t            flg_q, flg_d;

  // Combinational read port; a same-edge write is not bypassed.
  assign rdata = regs[readnum];

  // Write-back source select; only the target register captures it.
  always_comb begin
    wb_data = c_q;
    unique case (vsel)
      2'b00: wb_data = c_q;
      2'b01: wb_data = {{(DATA_W-PC_W){1'b0}}, pc};
      2'b10: wb_data = sximm8;
      2'b11: wb_data = mdata;
    endcase
  end

  // Register file write; reset wins over any pending write.
  always_ff @(posedge clk) begin
    if (rst) regs <= '0;
    else if (write) regs[writenum] <= wb_data;
  end

  // Operand registers A and B both sample the same read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      if (loada) a_q <= rdata;
      if (loadb) b_q <= rdata;
    end
  end

  // One-bit shifter on the B path; B itself stays untouched.
  always_comb begin
    b_sh = b_q;
    unique case (shift)
      2'b00: b_sh = b_q;
      2'b01: b_sh = {b_q[DATA_W-2:0], 1'b0};
      2'b10: b_sh = {1'b0, b_q[DATA_W-1:1]};
      2'b11: b_sh = {b_q[DATA_W-1], b_q[DATA_W-1:1]};
    endcase
  end

  assign ain = asel ? '0 : a_q;
  assign bin = bsel ? sximm5 : b_sh;

  // ALU with modulo arithmetic and Z/N/V derived from the result.
  always_comb begin
    result  = '0;
    flg_d.v = 1'b0;
    unique case (alu_op)
      2'b00: begin
        result  = ain + bin;
        flg_d.v = ~(ain[DATA_W-1] ^ bin[DATA_W-1]) & (ain[DATA_W-1] ^ result[DATA_W-1]);
      end
      2'b01: begin
        result  = ain - bin;
        flg_d.v = (ain[DATA_W-1] ^ bin[DATA_W-1]) & (ain[DATA_W-1] ^ result[DATA_W-1]);
      end
      2'b10: result = ain & bin;
      2'b11: result = ~bin;
    endcase
    flg_d.z = (result == '0);
    flg_d.n = result[DATA_W-1];
  end

  // Result register C and status flags load independently.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q   <= '0;
      flg_q <= '0;
    end else begin
      if (loadc) c_q   <= result;
      if (loads) flg_q <= flg_d;
    end
  end

  assign datapath_out = c_q;
  assign z_flag       = flg_q.z;
  assign n_flag       = flg_q.n;
  assign v_flag       = flg_q.v;

endmodule
